writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Single-port register-file writer. Merges a single-cycle ALU result stream and a long-latency memory/load result stream onto the one register-file write port (rd, data, write enable). ALU results win the port; memory results are buffered in a small FIFO and drained when the port is free. Older buffered writes that a newer ALU result overtakes are killed, which preserves write-after-write order. The block sits between the execute/memory stages and the register file.

## Interface
- DWIDTH, 32, data width of results and of the write port
- DEPTH, 4, memory-result FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- alu_valid_i  in  1  ALU result present this cycle; no backpressure
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  DWIDTH  ALU result
- alu_stall_o  out  1  registered; requests upstream to withhold ALU results
- mem_valid_i  in  1  memory result offered
- mem_ready_o  out  1  FIFO can accept; transfer when mem_valid_i && mem_ready_o
- mem_rd_i  in  5  memory destination register
- mem_data_i  in  DWIDTH  memory result
- rd_o  out  5  write-port destination (to register file rd)
- datawb_o  out  DWIDTH  write-port data
- regwren_o  out  1  write-port enable
- pending_o  out  32  bit r set when a live FIFO entry targets xr

## Operation
- FIFO entry holds: live bit, rd, data. Circular buffer with head/tail pointers and a count of 0..DEPTH.
- Push: on a memory transfer with mem_rd_i != 0, write the entry at the tail with live=1. On a transfer with mem_rd_i == 0, accept and discard the result; no push.
- Port select each cycle:
  - If alu_valid_i and alu_rd_i != 0, the ALU owns the port.
  - Otherwise, if count > 0, pop the head. If the head entry is live it owns the port; if dead it is popped with no write.
  - Otherwise the port is idle.
- ALU with rd == 0 does not use the port, so the FIFO may drain in that cycle.
- Kill: when the ALU owns the port with rd X, every live FIFO entry with rd X (entries resident at the start of the cycle) gets live=0.
  - An entry pushed in the same cycle with rd X is treated as younger and is not killed.
- pending_o: OR over live resident entries of one-hot(rd). Combinational from the FIFO state. Bit 0 is always 0.
- mem_ready_o = (count < DEPTH). Does not depend on a same-cycle pop.
- alu_stall_o: registered; set to 1 when count == DEPTH at the end of the cycle, otherwise 0.
  - Upstream contract: no alu_valid_i while alu_stall_o is high.
  - If alu_valid_i arrives anyway, the ALU still wins and no data is lost.
- Simultaneous push and pop: legal when count < DEPTH; count is unchanged.

## Timing
- Reset (async assert, sync release): regwren_o=0, rd_o=0, datawb_o=0, alu_stall_o=0, count=0, pointers=0, all live=0.
  - Consequently mem_ready_o=1 and pending_o=0.
  - Reset mid-drain discards all buffered entries; no write is issued afterward.
- Outputs rd_o, datawb_o and regwren_o are registered, one cycle after selection:
  - ALU result at cycle N gives regwren_o=1 at N+1.
  - Memory push at N, empty FIFO, no ALU: pop at N+1, regwren_o=1 at N+2. There is no bypass path.
- When the port is idle or a dead entry is popped, regwren_o=0 and rd_o/datawb_o hold their previous values.
- FIFO full (count == DEPTH): mem_ready_o=0 in the same cycle; alu_stall_o=1 from the next cycle.
- Pointer wrap: both pointers are modulo DEPTH.
- Count increments only on push without pop and decrements only on pop without push.

## Test plan
- Reset, then ALU rd=5, data=0xDEADBEEF at cycle 1 -> cycle 2: regwren_o=1, rd_o=5, datawb_o=0xDEADBEEF; pending_o=0 throughout.
- Empty FIFO, mem push rd=7, data=0x11 at cycle 1, ALU idle -> pending_o[7]=1 at cycle 2; regwren_o=1, rd_o=7 at cycle 3; pending_o=0 at cycle 3.
- Push rd=3 data=0xA, then ALU rd=3 data=0xB the next cycle -> exactly one write: rd=3, 0xB. The FIFO entry pops dead with regwren_o=0.
- Continuous ALU valid with rd≠0 while pushing 4 memory results:
  - mem_ready_o=0 after the 4th push; alu_stall_o=1 the next cycle.
  - Drop alu_valid_i -> 4 writes in push order on consecutive cycles; mem_ready_o=1 after the first pop.
- Memory transfer with rd=0 and ALU with rd=0 -> no write, no push; ALU rd=0 at cycle N still lets a queued entry write at N+1.
- Fill 3 entries, assert rst for 1 cycle mid-drain -> no further regwren_o; pending_o=0, mem_ready_o=1, all outputs 0.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Register-file writeback bundle: ALU and memory result streams in, write port out.
interface writeback_arbiter_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              alu_valid_i;
  logic [4:0]        alu_rd_i;
  logic [DWIDTH-1:0] alu_data_i;
  logic              alu_stall_o;
  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [4:0]        mem_rd_i;
  logic [DWIDTH-1:0] mem_data_i;
  logic [4:0]        rd_o;
  logic [DWIDTH-1:0] datawb_o;
  logic              regwren_o;
  logic [31:0]       pending_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, mem_valid_i, mem_rd_i, mem_data_i,
    input  alu_stall_o, mem_ready_o, rd_o, datawb_o, regwren_o, pending_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i, mem_valid_i, mem_rd_i, mem_data_i,
    output alu_stall_o, mem_ready_o, rd_o, datawb_o, regwren_o, pending_o
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Single write-port arbiter: ALU results take priority, memory results queue in a
// small FIFO; queued writes overtaken by a newer ALU write to the same rd are killed.
module writeback_arbiter #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   writeback_arbiter_if.slave  wb
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DEPTH-1:0]  live;
   logic [4:0]        rd_q   [DEPTH];
   logic [DWIDTH-1:0] data_q [DEPTH];
   logic [AW-1:0]     head, tail;
   logic [AW:0]       count, count_nxt;

   logic              alu_use, push, pop, mem_ready;
   logic              regwren_q, stall_q;
   logic [4:0]        rd_out_q;
   logic [DWIDTH-1:0] data_out_q;
   logic [31:0]       pending;

   always_comb begin
      alu_use   = wb.alu_valid_i && (wb.alu_rd_i != '0);
      mem_ready = (count < FULL);
      push      = wb.mem_valid_i && mem_ready && (wb.mem_rd_i != '0);
      pop       = !alu_use && (count != '0);
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;
   end

   always_comb begin
      pending = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (live[i])
            pending[rd_q[i]] = 1'b1;
      pending[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         live       <= '0;
         regwren_q  <= 1'b0;
         rd_out_q   <= '0;
         data_out_q <= '0;
         stall_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         count   <= count_nxt;
         stall_q <= (count_nxt == FULL);

         if (alu_use) begin
            regwren_q  <= 1'b1;
            rd_out_q   <= wb.alu_rd_i;
            data_out_q <= wb.alu_data_i;
            for (int unsigned i = 0; i < DEPTH; i++)
               if (rd_q[i] == wb.alu_rd_i)
                  live[i] <= 1'b0;
         end else if (pop) begin
            regwren_q <= live[head];
            if (live[head]) begin
               rd_out_q   <= rd_q[head];
               data_out_q <= data_q[head];
            end
            live[head] <= 1'b0;
            head       <= head + 1'b1;
         end else begin
            regwren_q <= 1'b0;
         end

         // Placed after the kill loop so a same-cycle push to the killed rd survives.
         if (push) begin
            live[tail]   <= 1'b1;
            rd_q[tail]   <= wb.mem_rd_i;
            data_q[tail] <= wb.mem_data_i;
            tail         <= tail + 1'b1;
         end
      end
   end

   assign wb.mem_ready_o = mem_ready;
   assign wb.alu_stall_o = stall_q;
   assign wb.regwren_o   = regwren_q;
   assign wb.rd_o        = rd_out_q;
   assign wb.datawb_o    = data_out_q;
   assign wb.pending_o   = pending;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: table of per-cycle vectors plus a reset-mid-drain sequence.
module tb_writeback_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   writeback_arbiter_if #(.DWIDTH(32)) wb ();

   writeback_arbiter #(.DWIDTH(32), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mr;
      logic [31:0] md;
      logic        ew;
      logic [4:0]  er;
      logic [31:0] ed;
      logic [31:0] ep;
      logic        erdy;
      logic        est;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
      wb.alu_valid_i = av;
      wb.alu_rd_i    = ar;
      wb.alu_data_i  = ad;
      wb.mem_valid_i = mv;
      wb.mem_rd_i    = mr;
      wb.mem_data_i  = md;
   endtask

   initial begin
      // {alu v,rd,data | mem v,rd,data | expected wren,rd,data,pending,ready,stall after the edge}
      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,   1'b1, 5'd5,  32'hDEADBEEF, 32'h0,    1'b1, 1'b0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd5,  32'hDEADBEEF, 32'h0,    1'b1, 1'b0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h11,  1'b0, 5'd5,  32'hDEADBEEF, 32'h80,   1'b1, 1'b0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd7,  32'h11,       32'h0,    1'b1, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hA,   1'b0, 5'd7,  32'h11,       32'h8,    1'b1, 1'b0};
      vecs[5]  = '{1'b1, 5'd3,  32'hB,        1'b0, 5'd0,  32'h0,   1'b1, 5'd3,  32'hB,        32'h0,    1'b1, 1'b0};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd3,  32'hB,        32'h0,    1'b1, 1'b0};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd3,  32'hB,        32'h0,    1'b1, 1'b0};
      vecs[8]  = '{1'b1, 5'd1,  32'h100,      1'b1, 5'd10, 32'h200, 1'b1, 5'd1,  32'h100,      32'h400,  1'b1, 1'b0};
      vecs[9]  = '{1'b1, 5'd2,  32'h101,      1'b1, 5'd11, 32'h201, 1'b1, 5'd2,  32'h101,      32'hC00,  1'b1, 1'b0};
      vecs[10] = '{1'b1, 5'd4,  32'h102,      1'b1, 5'd12, 32'h202, 1'b1, 5'd4,  32'h102,      32'h1C00, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 5'd6,  32'h103,      1'b1, 5'd13, 32'h203, 1'b1, 5'd6,  32'h103,      32'h3C00, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 32'h204, 1'b1, 5'd10, 32'h200,      32'h3800, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd11, 32'h201,      32'h3000, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd12, 32'h202,      32'h2000, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd13, 32'h203,      32'h0,    1'b1, 1'b0};
      vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd13, 32'h203,      32'h0,    1'b1, 1'b0};
      vecs[17] = '{1'b1, 5'd0,  32'h66,       1'b1, 5'd0,  32'h55,  1'b0, 5'd13, 32'h203,      32'h0,    1'b1, 1'b0};
      vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd13, 32'h203,      32'h0,    1'b1, 1'b0};
      vecs[19] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99,  1'b0, 5'd13, 32'h203,      32'h200,  1'b1, 1'b0};
      vecs[20] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0,  32'h0,   1'b1, 5'd9,  32'h99,       32'h0,    1'b1, 1'b0};
      vecs[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd9,  32'h99,       32'h0,    1'b1, 1'b0};
      vecs[22] = '{1'b1, 5'd8,  32'h1,        1'b1, 5'd8,  32'h2,   1'b1, 5'd8,  32'h1,        32'h100,  1'b1, 1'b0};
      vecs[23] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd8,  32'h2,        32'h0,    1'b1, 1'b0};
      vecs[24] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd8,  32'h2,        32'h0,    1'b1, 1'b0};

      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset wren",    32'(wb.regwren_o),   32'h0);
      chk("reset rd",      32'(wb.rd_o),        32'h0);
      chk("reset data",    wb.datawb_o,         32'h0);
      chk("reset pending", wb.pending_o,        32'h0);
      chk("reset ready",   32'(wb.mem_ready_o), 32'h1);
      chk("reset stall",   32'(wb.alu_stall_o), 32'h0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d wren", i),    32'(wb.regwren_o),   32'(vecs[i].ew));
         chk($sformatf("v%0d rd", i),      32'(wb.rd_o),        32'(vecs[i].er));
         chk($sformatf("v%0d data", i),    wb.datawb_o,         vecs[i].ed);
         chk($sformatf("v%0d pending", i), wb.pending_o,        vecs[i].ep);
         chk($sformatf("v%0d ready", i),   32'(wb.mem_ready_o), 32'(vecs[i].erdy));
         chk($sformatf("v%0d stall", i),   32'(wb.alu_stall_o), 32'(vecs[i].est));
      end

      // Queue three entries behind a busy ALU, drain one, then reset mid-drain.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd1, 32'h10, 1'b1, 5'(20 + i), 32'h300 + 32'(i));
         @(posedge clk);
         #1;
      end
      chk("fill pending", wb.pending_o, 32'h0070_0000);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      chk("drain wren", 32'(wb.regwren_o), 32'h1);
      chk("drain rd",   32'(wb.rd_o),      32'd20);
      chk("drain data", wb.datawb_o,       32'h300);
      #2 rst = 1'b1;
      #1;
      chk("midrst wren",    32'(wb.regwren_o),   32'h0);
      chk("midrst rd",      32'(wb.rd_o),        32'h0);
      chk("midrst data",    wb.datawb_o,         32'h0);
      chk("midrst pending", wb.pending_o,        32'h0);
      chk("midrst ready",   32'(wb.mem_ready_o), 32'h1);
      chk("midrst stall",   32'(wb.alu_stall_o), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("postrst%0d wren", i),    32'(wb.regwren_o), 32'h0);
         chk($sformatf("postrst%0d pending", i), wb.pending_o,      32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
